// File: rtl/vga_counter.sv
// Raster timing generator: pixel/line counters with combinational sync and
// visible-area decodes, so every output lines up with xValue/yValue.
module vga_counter #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        enableIn,
    output logic        inVisibleArea,
    output logic [31:0] xValue,
    output logic [31:0] yValue,
    output logic        HSync,
    output logic        VSync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS  = XW'(H_VISIBLE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] HS_END = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS  = YW'(V_VISIBLE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_VISIBLE + V_FRONT);
    localparam logic [YW-1:0] VS_END = YW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          hs_act;
    logic          vs_act;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (enableIn) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                // line and frame wrap land on the same edge at the last pixel
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        hs_act        = (x_cnt >= HS_BEG) && (x_cnt < HS_END);
        vs_act        = (y_cnt >= VS_BEG) && (y_cnt < VS_END);
        inVisibleArea = (x_cnt < X_VIS) && (y_cnt < Y_VIS);
        HSync         = HSYNC_POL ? hs_act : ~hs_act;
        VSync         = VSYNC_POL ? vs_act : ~vs_act;
        xValue        = 32'(x_cnt);
        yValue        = 32'(y_cnt);
    end
endmodule

// File: tb/tb_vga_counter.sv
// Directed bench: default 640x480 timing instance plus a tiny-timing instance
// (15x8 total, active-high HSync) used for the frame-level checks.
module tb_vga_counter;
    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        vis;
    logic [31:0] xv, yv;
    logic        hs, vs;

    logic        rst_s, en_s;
    logic        vis_s;
    logic [31:0] xv_s, yv_s;
    logic        hs_s, vs_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_counter dut (
        .clkIn(clk), .rstIn(rst_n), .enableIn(en),
        .inVisibleArea(vis), .xValue(xv), .yValue(yv), .HSync(hs), .VSync(vs)
    );

    vga_counter #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) dut_s (
        .clkIn(clk), .rstIn(rst_s), .enableIn(en_s),
        .inVisibleArea(vis_s), .xValue(xv_s), .yValue(yv_s), .HSync(hs_s), .VSync(vs_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then sample 1 time unit later
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, vs_low, hs_hi_s, vis_cnt;
        rst_n = 1'b0; en = 1'b0;
        rst_s = 1'b0; en_s = 1'b0;

        // 1: reset state, then held with enable low
        #1;
        chk("rst_x", xv, 0);
        chk("rst_y", yv, 0);
        chk("rst_vis", {31'd0, vis}, 1);
        chk("rst_hs", {31'd0, hs}, 1);
        chk("rst_vs", {31'd0, vs}, 1);
        step(1);
        rst_n = 1'b1; rst_s = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_xy", xv | yv, 0);
            chk("hold_out", {29'd0, vis, hs, vs}, 3'b111);
        end

        // 2: horizontal sweep of line 0
        en = 1'b1;
        step(1);
        chk("x_first", xv, 1);
        step(638);
        chk("x639", xv, 639);
        chk("vis639", {31'd0, vis}, 1);
        step(1);
        chk("x640", xv, 640);
        chk("vis640", {31'd0, vis}, 0);
        step(15);
        chk("hs655", {31'd0, hs}, 1);
        hs_low = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            if (!hs) hs_low++;
        end
        chk("x751", xv, 751);
        chk("hs_low_cnt", hs_low, 96);
        step(1);
        chk("hs752", {31'd0, hs}, 1);
        chk("vs_line0", {31'd0, vs}, 1);

        // 3: line wrap
        step(47);
        chk("x799", xv, 799);
        chk("y_before_wrap", yv, 0);
        step(1);
        chk("wrap_x", xv, 0);
        chk("wrap_y", yv, 1);
        chk("wrap_vis", {31'd0, vis}, 1);

        // 5: enable toggles every other clock
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            step(1);
            chk("toggle_x", xv, 32'((i / 2) + 1));
            chk("toggle_y", yv, 1);
        end
        en = 1'b1;

        // 6: asynchronous reset mid-frame, between edges
        step(296);
        chk("pre_rst_x", xv, 300);
        chk("pre_rst_y", yv, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", xv, 0);
        chk("async_rst_y", yv, 0);
        chk("async_rst_hs", {31'd0, hs}, 1);
        step(1);
        chk("rst_held_x", xv, 0);
        #2 rst_n = 1'b1;
        step(1);
        chk("restart_x", xv, 1);
        chk("restart_y", yv, 0);

        // 4: frame-level timing on the small instance (120 clocks per frame)
        en_s = 1'b1;
        vs_low = 0; hs_hi_s = 0; vis_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            if (!vs_s) vs_low++;
            if (hs_s) hs_hi_s++;
            if (vis_s) vis_cnt++;
            if (k == 74) chk("s_vs_before", {31'd0, vs_s}, 1);
            if (k == 75) chk("s_vs_start", {31'd0, vs_s}, 0);
            if (k == 104) chk("s_vs_last", {31'd0, vs_s}, 0);
            if (k == 105) chk("s_vs_after", {31'd0, vs_s}, 1);
            if (k == 119) chk("s_last_xy", {xv_s[15:0], yv_s[15:0]}, {16'd14, 16'd7});
            step(1);
        end
        chk("s_vs_cnt", vs_low, 30);
        chk("s_hs_cnt", hs_hi_s, 24);
        chk("s_vis_cnt", vis_cnt, 32);
        chk("s_frame_wrap", {xv_s[15:0], yv_s[15:0]}, 0);
        step(120);
        chk("s_frame2_wrap", {xv_s[15:0], yv_s[15:0]}, 0);
        step(10);
        chk("s_hs_x10", {31'd0, hs_s}, 1);
        chk("s_vis_x10", {31'd0, vis_s}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
